// File: rtl/r16_fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : r16_fft_ctrl
// Brief    : Phase sequencer (load/compute/drain/unload) for the radix-16
//            65536-point AGU, with source/sink valid-ready handshakes.
// Revision : 1.0
// ============================================================================
module r16_fft_ctrl #(
    parameter int CNT_WIDTH    = 15,
    parameter int LOAD_BEATS   = 4096,
    parameter int COMP_CYCLES  = 16432,
    parameter int DRAIN_CYCLES = 16,
    parameter int UNLOAD_BEATS = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 dout_ready,
    output logic                 dout_valid,
    output logic                 AGU_en,
    output logic                 rc_sel_out,
    output logic                 wrfd_en_out,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_COMP   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_UNLOAD = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO    = '0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_LOAD_LAST   = CNT_WIDTH'(LOAD_BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] c_COMP_LAST   = CNT_WIDTH'(COMP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_DRAIN_LAST  = CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_UNLOAD_LAST = CNT_WIDTH'(UNLOAD_BEATS - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter only advances on accepted beats in LOAD/UNLOAD; every cycle in COMP/DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = c_CNT_ZERO;
                if (start) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (din_valid) begin
                    if (r_cnt == c_LOAD_LAST) begin
                        w_state_nxt = c_ST_COMP;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_COMP: begin
                if (r_cnt == c_COMP_LAST) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = c_ST_UNLOAD;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_ST_UNLOAD: begin
                if (dout_ready) begin
                    if (r_cnt == c_UNLOAD_LAST) begin
                        w_state_nxt = c_ST_DONE;
                        w_cnt_nxt   = c_CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = c_CNT_ZERO;
        end
    end

    always_comb begin
        din_ready   = 1'b0;
        dout_valid  = 1'b0;
        AGU_en      = 1'b0;
        rc_sel_out  = 1'b0;
        wrfd_en_out = 1'b0;
        phase       = 3'd0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                din_ready  = 1'b1;
                rc_sel_out = 1'b1;
                AGU_en     = din_valid;
                phase      = c_ST_LOAD;
                busy       = 1'b1;
            end
            c_ST_COMP: begin
                AGU_en = 1'b1;
                phase  = c_ST_COMP;
                busy   = 1'b1;
            end
            c_ST_DRAIN: begin
                wrfd_en_out = 1'b1;
                phase       = c_ST_DRAIN;
                busy        = 1'b1;
            end
            c_ST_UNLOAD: begin
                dout_valid = 1'b1;
                rc_sel_out = 1'b1;
                AGU_en     = dout_ready;
                phase      = c_ST_UNLOAD;
                busy       = 1'b1;
            end
            c_ST_DONE: begin
                phase = c_ST_DONE;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: begin
                phase = 3'd0;
            end
        endcase
    end

    assign cnt_out = r_cnt;

endmodule
`default_nettype wire
